dynamic_output_arbiter: RTL
===========================

# dynamic_output_arbiter

Per-output-port wormhole arbiter for the dynamic network router. One instance sits in front of each output crossbar mux. It picks one of five input ports (0–4) whose head flit targets this output and drives the mux's 3-bit select. It holds that select for the packet's full length and pops the granted input FIFO. A downstream credit counter gates every flit.

## Interface
- CREDITS, 4: downstream buffer depth; initial and maximum credit count (≥1).
- LEN_WIDTH, 8: width of the payload-length field in a head flit (body flits following the head).

- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- route_req  in  5  bit i: head flit at front of input i targets this output.
- in_valid  in  5  bit i: input FIFO i non-empty.
- head_len  in  5*LEN_WIDTH  slice i = length field of input i's front flit; sampled only at head grant.
- credit_in  in  1  downstream freed one entry this cycle.
- sel  out  3  mux select; 0–4 = input port, 3'd7 = null (no transfer).
- valid_out  out  1  a flit crosses to the output this cycle.
- thanks  out  5  one-hot pop to input FIFO i; at most one bit set; equals a transfer.

## Operation
- State: IDLE / BUSY, owner[2:0], remaining[LEN_WIDTH-1:0], credits[$clog2(CREDITS+1)-1:0], prio[2:0] (round-robin pointer).
- xfer = valid_out; thanks = onehot(sel) & {5{xfer}}; sel = 3'd7 whenever xfer=0.
- IDLE, credits>0, route_req≠0: grant g = first set bit of route_req scanning prio, prio+1, … mod 5.
  - Grant transfers the head flit this cycle: sel=g, valid_out=1, thanks[g]=1.
  - head_len[g]==0: stay IDLE.
  - Otherwise: owner←g, remaining←head_len[g], go BUSY.
  - In both cases prio←(g+1) mod 5.
- IDLE with credits==0 or route_req==0: no transfer; route_req ignored.
- BUSY: route_req ignored (wormhole lock).
  - Transfer iff in_valid[owner] && credits>0: sel=owner, remaining←remaining-1.
  - Transfer with remaining==1: go IDLE.
  - in_valid[owner]=0 (bubble) or no credit: sel=7, no transfer, state held.
- Credits: credits←credits − xfer + credit_in. Simultaneous xfer and credit_in leaves the count unchanged.
  - credit_in at credits==CREDITS with no xfer is a protocol violation; counter holds at CREDITS (simulation assertion fires).
- Length field is unsigned; max packet = 2^LEN_WIDTH flits incl. head.

## Timing
- sel, valid_out and thanks are combinational from registered state plus route_req/in_valid/credits; zero-cycle grant latency.
- Head flit crosses in the grant cycle. Back-to-back body flits at 1 flit/cycle when in_valid and credits allow.
- Last body flit and a new head grant never share a cycle. The cycle after the tail transfer is IDLE and can grant, so there are no dead cycles between packets.
- Single-flit packet (len 0) allows a grant every cycle.
- Reset values: state IDLE, credits=CREDITS, prio=0, owner=0, remaining=0.
- While reset is high: sel=7, valid_out=0, thanks=0, regardless of inputs.
- Reset mid-packet drops the lock immediately; the next cycle after reset deasserts is IDLE.

## Configuration
- DYNAMIC_ARB_FIXED_PRIORITY_EN
  - Defined: fixed priority, input 0 highest through input 4 lowest; prio register removed.
  - Undefined (default): round-robin as above.
  - Wormhole lock and credit behaviour are identical in both builds.

## Test plan
- Single-input packet:
  - Stimulus: reset, then route_req=5'b00100, head_len[2]=3, in_valid[2]=1 continuously.
  - Required: sel=2 and thanks=5'b00100 for 4 consecutive cycles starting at the grant cycle; then sel=7; credits end at 0 with CREDITS=4 and no credit_in.
- Round-robin fairness:
  - Stimulus: route_req=5'b11111 held, all len=0, credit_in every cycle.
  - Required: grants 0,1,2,3,4,0,… one per cycle. With the macro defined: grant 0 every cycle.
- Wormhole lock:
  - Stimulus: port 1 granted with len=2; port 0 raises route_req the next cycle.
  - Required: sel=1 for both body flits; port 0 granted only in the following cycle.
- Bubble and credit stall:
  - Stimulus: in_valid[owner]=0 mid-packet for 2 cycles, then credits exhausted.
  - Required: sel=7, thanks=0, remaining unchanged; resumes on in_valid / credit_in.
- Simultaneous credit:
  - Stimulus: credits=0; credit_in=1 in the same cycle as a pending head.
  - Required: no transfer that cycle; transfer next cycle. At credits=2, xfer+credit_in together leave credits=2.
- Reset mid-packet:
  - Stimulus: assert reset with remaining=5.
  - Required: outputs null during reset; credits=4, prio=0 after; fresh head on port 3 granted in the first cycle after reset.

Source files
------------

// File: rtl/dynamic_output_arbiter.sv
// Wormhole output-port arbiter: grants one of five inputs, locks the crossbar select for the
// packet length, and gates every flit on downstream credit. Define DYNAMIC_ARB_FIXED_PRIORITY_EN for fixed priority.
module dynamic_output_arbiter #(
   parameter int CREDITS   = 4,
   parameter int LEN_WIDTH = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [4:0]                      route_req,
   input  logic [4:0]                      in_valid,
   input  logic [5*LEN_WIDTH-1:0]          head_len,
   input  logic                            credit_in,
   output logic [2:0]                      sel,
   output logic                            valid_out,
   output logic [4:0]                      thanks,
   output logic                            dbg_busy,
   output logic [$clog2(CREDITS+1)-1:0]    dbg_credits,
   output logic [LEN_WIDTH-1:0]            dbg_remaining
);

   localparam int CW = $clog2(CREDITS + 1);

   // Handshake: a flit moves iff valid_out is high; thanks is the matching one-hot pop, and
   // each transfer consumes one credit while each credit_in pulse returns one.
   typedef enum logic {IDLE, BUSY} state_t;

   state_t               state, state_n;
   logic [2:0]           owner, owner_n;
   logic [LEN_WIDTH-1:0] remaining, remaining_n;
   logic [CW-1:0]        credits, credits_n;
   logic                 has_credit;
   logic                 gnt_found;
   logic [2:0]           gnt;
   logic [LEN_WIDTH-1:0] gnt_len;
   logic [LEN_WIDTH-1:0] len_arr [5];

`ifndef DYNAMIC_ARB_FIXED_PRIORITY_EN
   logic [2:0]           prio, prio_n;
`endif

   assign has_credit = (credits != '0);

   always_comb begin
      for (int k = 0; k < 5; k++) begin
         len_arr[k] = head_len[k*LEN_WIDTH +: LEN_WIDTH];
      end
   end

   // Scan the requesters starting at the priority pointer (or at 0 in the fixed build).
   always_comb begin
      logic [2:0] idx;
`ifndef DYNAMIC_ARB_FIXED_PRIORITY_EN
      logic [3:0] sum;
`endif
      gnt_found = 1'b0;
      gnt       = 3'd0;
      gnt_len   = '0;
      idx       = 3'd0;
      for (int k = 0; k < 5; k++) begin
`ifdef DYNAMIC_ARB_FIXED_PRIORITY_EN
         idx = 3'(k);
`else
         sum = {1'b0, prio} + 4'(k);
         idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : 3'(sum);
`endif
         if (!gnt_found && route_req[idx]) begin
            gnt_found = 1'b1;
            gnt       = idx;
            gnt_len   = len_arr[idx];
         end
      end
   end

   always_comb begin
      state_n     = state;
      owner_n     = owner;
      remaining_n = remaining;
`ifndef DYNAMIC_ARB_FIXED_PRIORITY_EN
      prio_n      = prio;
`endif
      sel         = 3'd7;
      valid_out   = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (has_credit && gnt_found) begin
                  sel       = gnt;
                  valid_out = 1'b1;
`ifndef DYNAMIC_ARB_FIXED_PRIORITY_EN
                  prio_n    = (gnt == 3'd4) ? 3'd0 : gnt + 3'd1;
`endif
                  if (gnt_len != '0) begin
                     state_n     = BUSY;
                     owner_n     = gnt;
                     remaining_n = gnt_len;
                  end
               end
            end
            BUSY: begin
               if (in_valid[owner] && has_credit) begin
                  sel         = owner;
                  valid_out   = 1'b1;
                  remaining_n = remaining - LEN_WIDTH'(1);
                  if (remaining == LEN_WIDTH'(1)) state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign thanks = valid_out ? (5'd1 << sel) : 5'd0;

   // An excess credit_in at full count saturates rather than wrapping.
   always_comb begin
      credits_n = credits;
      if (valid_out && !credit_in) credits_n = credits - CW'(1);
      else if (!valid_out && credit_in && credits != CW'(CREDITS)) credits_n = credits + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= 3'd0;
         remaining <= '0;
         credits   <= CW'(CREDITS);
`ifndef DYNAMIC_ARB_FIXED_PRIORITY_EN
         prio      <= 3'd0;
`endif
      end else begin
         state     <= state_n;
         owner     <= owner_n;
         remaining <= remaining_n;
         credits   <= credits_n;
`ifndef DYNAMIC_ARB_FIXED_PRIORITY_EN
         prio      <= prio_n;
`endif
      end
   end

   assign dbg_busy      = (state == BUSY);
   assign dbg_credits   = credits;
   assign dbg_remaining = remaining;

   credit_overflow_a: assert property (@(posedge clk) disable iff (reset)
      !(credit_in && !valid_out && credits == CW'(CREDITS)));

endmodule
